// File: rtl/relay_driver_if.sv
// Relay driver bus: controller requests in, coil drive and status out.
interface relay_driver_if #(
  parameter int N_CH = 3
);
  logic [N_CH-1:0] req;
  logic            force_off;
  logic [N_CH-1:0] relay_out;
  logic [N_CH-1:0] pending;
  logic            busy;
  logic            sw_evt;
  logic [1:0]      sw_idx;

  modport master (
    output req, force_off,
    input  relay_out, pending, busy, sw_evt, sw_idx
  );

  modport slave (
    input  req, force_off,
    output relay_out, pending, busy, sw_evt, sw_idx
  );
endinterface

// File: rtl/relay_driver.sv
// Relay coil driver: per-channel minimum on/off dwell, one granted transition
// per stagger window in round-robin order, and an immediate global force-off.
module relay_driver #(
  parameter int N_CH    = 3,
  parameter int MIN_ON  = 16,
  parameter int MIN_OFF = 16,
  parameter int STAGGER = 8,
  parameter int CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  relay_driver_if.slave  bus
);

  localparam int GAP_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] DWELL_MAX  = '1;
  localparam logic [CNT_W-1:0] MIN_ON_C   = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] MIN_OFF_C  = CNT_W'(MIN_OFF);

  logic [N_CH-1:0]  relay_q, relay_d;
  logic [CNT_W-1:0] dwell_q [N_CH];
  logic [CNT_W-1:0] dwell_d [N_CH];
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       sw_idx_q, sw_idx_d;
  logic             sw_evt_q, sw_evt_d;
  logic             busy_q;

  logic [N_CH-1:0]  want;
  logic [N_CH-1:0]  elig;
  logic             found;

  // Effective request: force_off masks every turn-on.
  assign want = bus.req & ~{N_CH{bus.force_off}};

  // Per-channel eligibility from request, current drive and dwell time.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_CH; i++) begin
      elig[i] = (want[i] & ~relay_q[i] & (dwell_q[i] >= MIN_OFF_C)) |
                (~bus.req[i] & relay_q[i] & (dwell_q[i] >= MIN_ON_C));
    end
  end

  // Next state: force-off clears everything at once, else one round-robin grant when the gap is idle.
  always_comb begin
    relay_d  = relay_q;
    rr_d     = rr_q;
    sw_evt_d = 1'b0;
    sw_idx_d = sw_idx_q;
    found    = 1'b0;
    gap_d    = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
    for (int i = 0; i < N_CH; i++) begin
      dwell_d[i] = (dwell_q[i] == DWELL_MAX) ? dwell_q[i] : dwell_q[i] + 1'b1;
    end
    if (bus.force_off && (|relay_q)) begin
      relay_d  = '0;
      gap_d    = GAP_RELOAD;
      sw_evt_d = 1'b1;
      // Descending scan so the lowest cleared channel is reported.
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (relay_q[i]) begin
          dwell_d[i] = CNT_W'(1);
          sw_idx_d   = 2'(i);
        end
      end
    end else if (gap_q == '0) begin
      // Offset k from the pointer; channel i matches k when (rr+k) mod N_CH == i.
      for (int k = 0; k < N_CH; k++) begin
        for (int i = 0; i < N_CH; i++) begin
          if (!found && elig[i] &&
              ((int'(rr_q) + k == i) || (int'(rr_q) + k == i + N_CH))) begin
            found      = 1'b1;
            relay_d[i] = ~relay_q[i];
            dwell_d[i] = CNT_W'(1);
            rr_d       = (i == N_CH - 1) ? 2'd0 : 2'(i + 1);
            gap_d      = GAP_RELOAD;
            sw_evt_d   = 1'b1;
            sw_idx_d   = 2'(i);
          end
        end
      end
    end
  end

  // State registers; reset saturates dwell so the first turn-on is immediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relay_q  <= '0;
      gap_q    <= '0;
      rr_q     <= '0;
      sw_idx_q <= '0;
      sw_evt_q <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) dwell_q[i] <= DWELL_MAX;
    end else begin
      relay_q  <= relay_d;
      gap_q    <= gap_d;
      rr_q     <= rr_d;
      sw_idx_q <= sw_idx_d;
      sw_evt_q <= sw_evt_d;
      busy_q   <= (gap_d != '0);
      for (int i = 0; i < N_CH; i++) dwell_q[i] <= dwell_d[i];
    end
  end

  assign bus.relay_out = relay_q;
  assign bus.pending   = want ^ relay_q;
  assign bus.busy      = busy_q;
  assign bus.sw_evt    = sw_evt_q;
  assign bus.sw_idx    = sw_idx_q;

endmodule
